id_stage_hz: RTL

Parametrised successor to the current decode stage: holds the IF/ID pipeline register, decodes the extended MIPS integer subset, and resolves branches and jumps in ID. Operands are forwarded from a configurable number of downstream stages plus the WB write port. The block detects load-use hazards and raises `stallreq`, and keeps the fetched instruction stable while ID is stalled. It sits between IF and EX and owns the 32×32 register file instance.

---
 rtl/id_stage_hz_pkg.sv | 121 ++++++++++++
 rtl/id_stage_hz_branch_unit.sv | 36 +++
 rtl/regfile.sv | 20 ++
 rtl/id_stage_hz.sv | 125 ++++++++++++
 4 files changed

// File: rtl/id_stage_hz_pkg.sv
// Shared decode definitions for the ID stage: opcodes, functs, alu_op bit positions,
// operand-select encodings, forwarding slice width, stall bit indices and the decoder.
package id_stage_hz_pkg;

    localparam int FWD_W      = 39;
    localparam int STALL_IFID = 1;
    localparam int STALL_IDEX = 2;

    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02,
                           OP_JAL     = 6'h03, OP_BEQ    = 6'h04, OP_BNE   = 6'h05,
                           OP_BLEZ    = 6'h06, OP_BGTZ   = 6'h07, OP_ADDIU = 6'h09,
                           OP_SLTI    = 6'h0A, OP_SLTIU  = 6'h0B, OP_ANDI  = 6'h0C,
                           OP_ORI     = 6'h0D, OP_XORI   = 6'h0E, OP_LUI   = 6'h0F,
                           OP_LW      = 6'h23, OP_SW     = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_JR   = 6'h08,
                           FN_JALR = 6'h09, FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_AND = 6'h24,
                           FN_OR   = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27, FN_SLT  = 6'h2A,
                           FN_SLTU = 6'h2B;

    localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01;

    localparam int ALU_ADD = 11, ALU_SUB = 10, ALU_SLT = 9, ALU_SLTU = 8, ALU_AND = 7, ALU_NOR = 6,
                   ALU_OR  = 5,  ALU_XOR = 4,  ALU_SLL = 3, ALU_SRL  = 2, ALU_SRA = 1, ALU_LUI = 0;

    localparam logic [2:0] S1_RS = 3'b100, S1_PC = 3'b010, S1_SA = 3'b001;
    localparam logic [3:0] S2_RT = 4'b1000, S2_SIMM = 4'b0100, S2_8 = 4'b0010, S2_ZIMM = 4'b0001;

    typedef enum logic [3:0] {
        BR_NONE, BR_BEQ, BR_BNE, BR_BGEZ, BR_BLTZ, BR_BGTZ, BR_BLEZ, BR_J, BR_JR
    } br_type_e;

    typedef struct packed {
        logic [11:0] alu_op;
        logic [2:0]  src1_sel;
        logic [3:0]  src2_sel;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        rf_res_sel;
        logic        use_rs;
        logic        use_rt;
        br_type_e    br_type;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] inst);
        dec_t       d;
        logic       wr;
        logic [4:0] dst;
        d   = '0;
        wr  = 1'b0;
        dst = inst[20:16];
        case (inst[31:26])
            OP_SPECIAL: begin
                wr = 1'b1; dst = inst[15:11]; d.use_rs = 1'b1; d.use_rt = 1'b1;
                d.src1_sel = S1_RS; d.src2_sel = S2_RT;
                case (inst[5:0])
                    FN_ADDU: d.alu_op[ALU_ADD]  = 1'b1;
                    FN_SUBU: d.alu_op[ALU_SUB]  = 1'b1;
                    FN_AND:  d.alu_op[ALU_AND]  = 1'b1;
                    FN_OR:   d.alu_op[ALU_OR]   = 1'b1;
                    FN_XOR:  d.alu_op[ALU_XOR]  = 1'b1;
                    FN_NOR:  d.alu_op[ALU_NOR]  = 1'b1;
                    FN_SLT:  d.alu_op[ALU_SLT]  = 1'b1;
                    FN_SLTU: d.alu_op[ALU_SLTU] = 1'b1;
                    FN_SLL:  begin d.alu_op[ALU_SLL] = 1'b1; d.use_rs = 1'b0; d.src1_sel = S1_SA; end
                    FN_SRL:  begin d.alu_op[ALU_SRL] = 1'b1; d.use_rs = 1'b0; d.src1_sel = S1_SA; end
                    FN_SRA:  begin d.alu_op[ALU_SRA] = 1'b1; d.use_rs = 1'b0; d.src1_sel = S1_SA; end
                    FN_JR:   begin wr = 1'b0; d.br_type = BR_JR; d.src1_sel = '0; d.src2_sel = '0; end
                    FN_JALR: begin
                        d.br_type = BR_JR; d.alu_op[ALU_ADD] = 1'b1;
                        d.src1_sel = S1_PC; d.src2_sel = S2_8;
                    end
                    default: begin
                        wr = 1'b0; d.use_rs = 1'b0; d.use_rt = 1'b0; d.src1_sel = '0; d.src2_sel = '0;
                    end
                endcase
            end
            OP_REGIMM: begin
                case (inst[20:16])
                    RT_BLTZ: begin d.use_rs = 1'b1; d.br_type = BR_BLTZ; end
                    RT_BGEZ: begin d.use_rs = 1'b1; d.br_type = BR_BGEZ; end
                    default: d.br_type = BR_NONE;
                endcase
            end
            OP_J:   d.br_type = BR_J;
            OP_JAL: begin
                wr = 1'b1; dst = 5'd31; d.br_type = BR_J; d.alu_op[ALU_ADD] = 1'b1;
                d.src1_sel = S1_PC; d.src2_sel = S2_8;
            end
            OP_BEQ:  begin d.use_rs = 1'b1; d.use_rt = 1'b1; d.br_type = BR_BEQ; end
            OP_BNE:  begin d.use_rs = 1'b1; d.use_rt = 1'b1; d.br_type = BR_BNE; end
            OP_BLEZ: begin d.use_rs = 1'b1; d.br_type = BR_BLEZ; end
            OP_BGTZ: begin d.use_rs = 1'b1; d.br_type = BR_BGTZ; end
            OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LW: begin
                wr = 1'b1; d.use_rs = 1'b1; d.src1_sel = S1_RS; d.src2_sel = S2_SIMM;
                case (inst[31:26])
                    OP_SLTI:  d.alu_op[ALU_SLT]  = 1'b1;
                    OP_SLTIU: d.alu_op[ALU_SLTU] = 1'b1;
                    OP_ANDI:  begin d.alu_op[ALU_AND] = 1'b1; d.src2_sel = S2_ZIMM; end
                    OP_ORI:   begin d.alu_op[ALU_OR]  = 1'b1; d.src2_sel = S2_ZIMM; end
                    OP_XORI:  begin d.alu_op[ALU_XOR] = 1'b1; d.src2_sel = S2_ZIMM; end
                    OP_LW:    begin d.alu_op[ALU_ADD] = 1'b1; d.ram_en = 1'b1; d.rf_res_sel = 1'b1; end
                    default:  d.alu_op[ALU_ADD] = 1'b1;
                endcase
            end
            OP_LUI: begin wr = 1'b1; d.alu_op[ALU_LUI] = 1'b1; d.src2_sel = S2_ZIMM; end
            OP_SW: begin
                d.use_rs = 1'b1; d.use_rt = 1'b1; d.alu_op[ALU_ADD] = 1'b1;
                d.src1_sel = S1_RS; d.src2_sel = S2_SIMM; d.ram_en = 1'b1; d.ram_wen = 4'hF;
            end
            default: d = '0;
        endcase
        // A write to $0 is dropped entirely, so the destination also reads back as 0
        d.rf_we    = wr && (dst != 5'd0);
        d.rf_waddr = d.rf_we ? dst : 5'd0;
        return d;
    endfunction

endpackage

// File: rtl/id_stage_hz_branch_unit.sv
// Branch/jump resolution in ID: condition compare on forwarded operands and target mux.
module id_branch_unit
    import id_stage_hz_pkg::*;
(
    input  br_type_e    br_type,
    input  logic [31:0] pc,
    input  logic [25:0] inst_idx,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        taken,
    output logic [31:0] target
);
    logic        [31:0] pc4;
    logic signed [31:0] rs_s;
    logic signed [31:0] boff;

    assign pc4  = pc + 32'd4;
    assign rs_s = rs_data;
    assign boff = {{14{inst_idx[15]}}, inst_idx[15:0], 2'b00};

    always_comb begin
        taken  = 1'b0;
        target = pc4 + $unsigned(boff);
        case (br_type)
            BR_BEQ:  taken = (rs_data == rt_data);
            BR_BNE:  taken = (rs_data != rt_data);
            BR_BGEZ: taken = (rs_s >= 0);
            BR_BLTZ: taken = (rs_s < 0);
            BR_BGTZ: taken = (rs_s > 0);
            BR_BLEZ: taken = (rs_s <= 0);
            BR_J:    begin taken = 1'b1; target = {pc4[31:28], inst_idx, 2'b00}; end
            BR_JR:   begin taken = 1'b1; target = rs_data; end
            default: taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port.
module regfile (
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);
    logic [31:0] mem [32];

    always_ff @(posedge clk) begin
        if (we && waddr != 5'd0) mem[waddr] <= wdata;
    end

    assign rdata1 = mem[raddr1];
    assign rdata2 = mem[raddr2];
endmodule

// File: rtl/id_stage_hz.sv
// Decode stage: IF/ID register with instruction hold buffer, decode, operand forwarding,
// load-use interlock and branch resolution.
module id_stage_hz
    import id_stage_hz_pkg::*;
#(
    parameter int NUM_FWD = 2,
    parameter int STALL_W = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [STALL_W-1:0]       stall,
    input  logic                     if_valid,
    input  logic [31:0]              if_pc,
    input  logic [31:0]              inst_sram_rdata,
    input  logic                     wb_we,
    input  logic [4:0]               wb_waddr,
    input  logic [31:0]              wb_wdata,
    input  logic [NUM_FWD*FWD_W-1:0] fwd_bus,
    output logic                     stallreq,
    output logic                     id_valid,
    output logic [31:0]              id_pc,
    output logic [31:0]              id_inst,
    output logic [11:0]              alu_op,
    output logic [2:0]               src1_sel,
    output logic [3:0]               src2_sel,
    output logic                     ram_en,
    output logic [3:0]               ram_wen,
    output logic                     rf_we,
    output logic [4:0]               rf_waddr,
    output logic                     rf_res_sel,
    output logic [31:0]              rs_data,
    output logic [31:0]              rt_data,
    output logic                     br_e,
    output logic [31:0]              br_addr
);
    logic        valid_p0, hold_v_p0;
    logic [31:0] pc_p0, hold_inst_p0, inst;
    logic [31:0] rf_rdata1, rf_rdata2, br_target;
    logic        br_taken, ld_s0, unused_stall;
    dec_t        dec_raw, dec;

    assign unused_stall = ^stall;

    // IF/ID boundary: load, bubble or hold; first held cycle latches the SRAM word
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_p0  <= 1'b0;
            pc_p0     <= '0;
            hold_v_p0 <= 1'b0;
        end else if (stall[STALL_IFID] && !stall[STALL_IDEX]) begin
            valid_p0  <= 1'b0;
            hold_v_p0 <= 1'b0;
        end else if (!stall[STALL_IFID]) begin
            valid_p0  <= if_valid;
            pc_p0     <= if_pc;
            hold_v_p0 <= 1'b0;
        end else if (!hold_v_p0) begin
            hold_v_p0 <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (stall[STALL_IDEX] && !hold_v_p0) hold_inst_p0 <= inst_sram_rdata;
    end

    assign inst    = !valid_p0 ? 32'd0 : (hold_v_p0 ? hold_inst_p0 : inst_sram_rdata);
    assign dec_raw = decode(inst);
    assign dec     = valid_p0 ? dec_raw : '0;

    regfile u_regfile (
        .clk    (clk),
        .we     (wb_we),
        .waddr  (wb_waddr),
        .wdata  (wb_wdata),
        .raddr1 (inst[25:21]),
        .raddr2 (inst[20:16]),
        .rdata1 (rf_rdata1),
        .rdata2 (rf_rdata2)
    );

    // Walk from the oldest slot down so the nearest matching producer wins
    function automatic logic [31:0] operand(input logic [4:0] ra, input logic [31:0] rf_val);
        logic [31:0] v;
        v = rf_val;
        if (wb_we && wb_waddr == ra) v = wb_wdata;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_bus[i*FWD_W + 37] && fwd_bus[i*FWD_W + 32 +: 5] == ra) v = fwd_bus[i*FWD_W +: 32];
        end
        if (ra == 5'd0) v = '0;
        return v;
    endfunction

    assign rs_data = operand(inst[25:21], rf_rdata1);
    assign rt_data = operand(inst[20:16], rf_rdata2);

    assign ld_s0    = fwd_bus[38] && fwd_bus[37] && (fwd_bus[36:32] != 5'd0);
    assign stallreq = valid_p0 && ld_s0 &&
                      ((dec.use_rs && fwd_bus[36:32] == inst[25:21]) ||
                       (dec.use_rt && fwd_bus[36:32] == inst[20:16]));

    id_branch_unit u_branch (
        .br_type  (dec.br_type),
        .pc       (pc_p0),
        .inst_idx (inst[25:0]),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .taken    (br_taken),
        .target   (br_target)
    );

    assign br_e    = valid_p0 && br_taken && !stallreq;
    assign br_addr = br_e ? br_target : 32'd0;

    assign id_valid   = valid_p0;
    assign id_pc      = pc_p0;
    assign id_inst    = inst;
    assign alu_op     = dec.alu_op;
    assign src1_sel   = dec.src1_sel;
    assign src2_sel   = dec.src2_sel;
    assign ram_en     = dec.ram_en;
    assign ram_wen    = dec.ram_wen;
    assign rf_we      = dec.rf_we;
    assign rf_waddr   = dec.rf_waddr;
    assign rf_res_sel = dec.rf_res_sel;
endmodule
